// File: rtl/mips_run_ctrl_pkg.sv
// mips_run_ctrl shared types.
// Run modes, FSM states and a sizing helper.
package mips_run_ctrl_pkg;

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_BURST,
    ST_STOP
  } state_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_down_counter.sv
// Loadable down-counter shared by reset sequencing
// and burst length tracking.
module run_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_zero,
  output logic         is_one
);

  // load has priority over decrement
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == W'(1));

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: reset sequencing,
// run modes, cycle counting, halt capture, watchdog.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int BURST_W      = 16,
  parameter int TIMEOUT      = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               go,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt,
  output logic               cpu_reset,
  output logic               cpu_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               step_done,
  output logic               halted,
  output logic               timed_out
);

  localparam int DW =
    max_int(BURST_W, $clog2(RESET_CYCLES));

  state_t          state;
  logic            cnt_load;
  logic            cnt_dec;
  logic [DW-1:0]   cnt_val;
  logic [DW-1:0]   cnt;
  logic            cnt_zero;
  logic            cnt_one;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nxt;
  logic            wd_hit;
  logic            fin;

  run_down_counter #(
    .W(DW)
  ) u_cnt (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  // cycle counter lookahead, watchdog and completion
  always_comb begin
    cnt_inc = (cycle_count == '1) ?
              cycle_count : cycle_count + 1'b1;
    cnt_nxt = cpu_en ? cnt_inc : cycle_count;
    wd_hit  = (TIMEOUT != 0) &&
              (cnt_nxt == CNT_W'(TIMEOUT));
    fin     = cpu_en &&
              ((state == ST_STEP) ||
               ((state == ST_BURST) && cnt_one));
  end

  // down-counter: reset length or burst length
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = DW'(burst_len);
    if (reset) begin
      cnt_load = 1'b1;
      cnt_val  = DW'(RESET_CYCLES - 1);
    end else if (state == ST_IDLE && go &&
                 mode == MODE_BURST) begin
      cnt_load = 1'b1;
    end else if (state == ST_RST) begin
      cnt_dec = !cnt_zero;
    end else if (state == ST_BURST) begin
      cnt_dec = cpu_en && !cnt_one;
    end
  end

  // run FSM with registered core controls and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RST;
      cpu_reset   <= 1'b1;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
      step_done   <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (cpu_en) begin
        cycle_count <= cnt_inc;
      end
      unique case (state)
        ST_RST: begin
          if (cnt_zero) begin
            state     <= ST_IDLE;
            cpu_reset <= 1'b0;
          end
        end
        ST_STOP: begin
          cpu_en    <= 1'b0;
          cpu_reset <= 1'b0;
        end
        ST_IDLE, ST_RUN, ST_STEP, ST_BURST: begin
          if (halt) begin
            state  <= ST_STOP;
            cpu_en <= 1'b0;
            halted <= 1'b1;
          end else if (wd_hit) begin
            state     <= ST_STOP;
            cpu_en    <= 1'b0;
            timed_out <= 1'b1;
          end else if (fin) begin
            state     <= ST_IDLE;
            cpu_en    <= 1'b0;
            step_done <= 1'b1;
          end else if (state == ST_IDLE) begin
            cpu_en <= 1'b0;
            if (go) begin
              unique case (mode)
                MODE_FREE:  state <= ST_RUN;
                MODE_STEP:  state <= ST_STEP;
                MODE_BURST: begin
                  if (burst_len != '0) begin
                    state <= ST_BURST;
                  end else begin
                    step_done <= 1'b1;
                  end
                end
                MODE_HOLD:  state <= ST_IDLE;
              endcase
            end
          end else if (state == ST_RUN &&
                       mode == MODE_HOLD) begin
            state  <= ST_IDLE;
            cpu_en <= 1'b0;
          end else begin
            cpu_en <= 1'b1;
          end
        end
        default: begin
          state  <= ST_STOP;
          cpu_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: per-cycle output scoreboard
// plus counter and flag checks on a watchdog variant.
module tb_mips_run_ctrl;
  import mips_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = MODE_HOLD;
  logic        go = 1'b0;
  logic [15:0] burst_len = '0;
  logic        halt = 1'b0;

  logic        a_rst, a_en, a_sd, a_hlt, a_to;
  logic [31:0] a_cnt;
  logic        w_rst, w_en, w_sd, w_hlt, w_to;
  logic [31:0] w_cnt;

  always #5 clk = ~clk;

  mips_run_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .go          (go),
    .burst_len   (burst_len),
    .halt        (halt),
    .cpu_reset   (a_rst),
    .cpu_en      (a_en),
    .cycle_count (a_cnt),
    .step_done   (a_sd),
    .halted      (a_hlt),
    .timed_out   (a_to)
  );

  mips_run_ctrl #(
    .TIMEOUT(20)
  ) u_wdt (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .go          (go),
    .burst_len   (burst_len),
    .halt        (halt),
    .cpu_reset   (w_rst),
    .cpu_en      (w_en),
    .cycle_count (w_cnt),
    .step_done   (w_sd),
    .halted      (w_hlt),
    .timed_out   (w_to)
  );

  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // vector order: cpu_reset cpu_en step_done halted timed_out
  localparam logic [4:0] V_RST  = 5'b10000;
  localparam logic [4:0] V_OFF  = 5'b00000;
  localparam logic [4:0] V_EN   = 5'b01000;
  localparam logic [4:0] V_DONE = 5'b00100;
  localparam logic [4:0] V_HLT  = 5'b00010;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic push(string tag, logic [4:0] v, int n);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    repeat (n) sb.push_back(e);
  endtask

  task automatic run(int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.tag, 32'({a_rst, a_en, a_sd, a_hlt, a_to}),
            32'(e.v));
      end else begin
        chk("sb_underflow", sb.size(), 1);
      end
    end
  endtask

  task automatic do_reset(int n_hi);
    reset = 1'b1;
    go    = 1'b0;
    halt  = 1'b0;
    push("rst_hold", V_RST, n_hi);
    run(n_hi);
    chk("rst_cnt", a_cnt, 0);
    reset = 1'b0;
    push("rst_seq", V_RST, 3);
    push("rst_rel", V_OFF, 1);
    run(4);
  endtask

  initial begin
    // reset release and idle
    do_reset(2);
    push("idle", V_OFF, 2);
    run(2);
    chk("idle_cnt", a_cnt, 0);

    // three single steps
    mode = MODE_STEP;
    for (int i = 0; i < 3; i++) begin
      go = 1'b1;
      push("step_go", V_OFF, 1);
      run(1);
      go = 1'b0;
      push("step_en", V_EN, 1);
      push("step_done", V_DONE, 1);
      push("step_idle", V_OFF, 2);
      run(4);
    end
    chk("step_cnt", a_cnt, 3);

    // burst of 5 then zero-length burst
    do_reset(1);
    mode      = MODE_BURST;
    burst_len = 16'd5;
    go        = 1'b1;
    push("burst_go", V_OFF, 1);
    run(1);
    go = 1'b0;
    push("burst_en", V_EN, 5);
    push("burst_done", V_DONE, 1);
    push("burst_idle", V_OFF, 1);
    run(7);
    chk("burst_cnt", a_cnt, 5);
    burst_len = 16'd0;
    go        = 1'b1;
    push("burst0_done", V_DONE, 1);
    run(1);
    go = 1'b0;
    push("burst0_idle", V_OFF, 2);
    run(2);
    chk("burst0_cnt", a_cnt, 5);

    // free run halted on 10th enabled cycle
    do_reset(1);
    mode = MODE_FREE;
    go   = 1'b1;
    push("free_go", V_OFF, 1);
    run(1);
    go = 1'b0;
    push("free_en", V_EN, 10);
    run(10);
    halt = 1'b1;
    push("free_halt", V_HLT, 1);
    run(1);
    halt = 1'b0;
    chk("halt_cnt", a_cnt, 10);
    go = 1'b1;
    push("stop_go", V_HLT, 3);
    run(3);
    go = 1'b0;
    chk("stop_cnt", a_cnt, 10);

    // watchdog at 20 enabled cycles
    do_reset(1);
    go = 1'b1;
    push("wd_go", V_OFF, 1);
    run(1);
    go = 1'b0;
    push("wd_free", V_EN, 25);
    run(25);
    chk("wd_cnt", w_cnt, 20);
    chk("wd_to", 32'(w_to), 1);
    chk("wd_en", 32'(w_en), 0);
    chk("wd_hlt", 32'(w_hlt), 0);

    // halt coincident with watchdog
    do_reset(1);
    go = 1'b1;
    push("wdh_go", V_OFF, 1);
    run(1);
    go = 1'b0;
    push("wdh_en", V_EN, 20);
    run(20);
    halt = 1'b1;
    push("wdh_halt", V_HLT, 1);
    run(1);
    halt = 1'b0;
    chk("wdh_cnt", w_cnt, 20);
    chk("wdh_hlt", 32'(w_hlt), 1);
    chk("wdh_to", 32'(w_to), 0);
    chk("wdh_a_cnt", a_cnt, 20);

    // reset in the middle of a long burst
    do_reset(1);
    mode      = MODE_BURST;
    burst_len = 16'd100;
    go        = 1'b1;
    push("mid_go", V_OFF, 1);
    run(1);
    go = 1'b0;
    push("mid_en", V_EN, 30);
    run(30);
    chk("mid_cnt", a_cnt, 29);
    do_reset(1);
    chk("mid_rst_cnt", a_cnt, 0);
    push("mid_idle", V_OFF, 2);
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
